// File: rtl/reg_dst_queue.sv
// Write-destination selector with an in-order queue of pending destinations and a hazard probe.
// Optional REGDST_BYPASS_EN: empty-queue fall-through to the head and probe match on the incoming push.
module reg_dst_queue #(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 4,
  parameter int CONST_A = 29,
  parameter int CONST_B = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               regDSTmux,
  input  logic [ADDR_W-1:0]        inst20_16,
  input  logic [ADDR_W-1:0]        inst15_11,
  input  logic [ADDR_W-1:0]        inst25_21,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        probe_addr,
  output logic [ADDR_W-1:0]        sel_dst,
  output logic [ADDR_W-1:0]        head_dst,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     probe_hit,
  output logic                     sel_err,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] CONST_A_C = ADDR_W'(CONST_A);
  localparam logic [ADDR_W-1:0] CONST_B_C = ADDR_W'(CONST_B);

  logic [ADDR_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  valid_reg, valid_next;
  logic [PW-1:0]     rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [ADDR_W-1:0] head_dst_reg, head_dst_next;
  logic              head_valid_reg, head_valid_next;
  logic              full_reg, empty_reg, sel_err_reg, ovf_reg, unf_reg;
  logic [ADDR_W-1:0] sel_dst_c;
  logic              sel_legal, push_ok, pop_ok;
  logic [DEPTH-1:0]  match;
  logic              byp_hit;

  always_comb begin
    sel_dst_c = '0;
    sel_legal = 1'b1;
    case (regDSTmux)
      3'b000:  sel_dst_c = inst20_16;
      3'b001:  sel_dst_c = inst15_11;
      3'b010:  sel_dst_c = CONST_A_C;
      3'b011:  sel_dst_c = CONST_B_C;
      3'b100:  sel_dst_c = inst25_21;
      default: begin
        sel_dst_c = '0;
        sel_legal = 1'b0;
      end
    endcase
  end

  assign sel_dst = sel_dst_c;
  // A concurrent pop frees a slot, so a full queue still accepts the push.
  assign push_ok = push && sel_legal && ((count_reg != DEPTH_C) || pop);
  assign pop_ok  = pop && (count_reg != '0);

  always_comb begin
    rd_ptr_next = pop_ok  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    wr_ptr_next = push_ok ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    count_next  = count_reg + CW'(push_ok) - CW'(pop_ok);
    valid_next  = valid_reg;
    if (pop_ok)
      valid_next[rd_ptr_reg] = 1'b0;
    if (push_ok)
      valid_next[wr_ptr_reg] = 1'b1;
    head_valid_next = (count_next != '0);
    // The entry being written this cycle may itself become the new head.
    if (!head_valid_next)
      head_dst_next = '0;
    else if (push_ok && (wr_ptr_reg == rd_ptr_next))
      head_dst_next = sel_dst_c;
    else
      head_dst_next = mem_reg[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok)
      mem_reg[wr_ptr_reg] <= sel_dst_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      valid_reg      <= '0;
      head_dst_reg   <= '0;
      head_valid_reg <= 1'b0;
      full_reg       <= 1'b0;
      empty_reg      <= 1'b1;
      sel_err_reg    <= 1'b0;
      ovf_reg        <= 1'b0;
      unf_reg        <= 1'b0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      valid_reg      <= valid_next;
      head_dst_reg   <= head_dst_next;
      head_valid_reg <= head_valid_next;
      full_reg       <= (count_next == DEPTH_C);
      empty_reg      <= (count_next == '0);
      sel_err_reg    <= push && !sel_legal;
      if (push && sel_legal && !push_ok)
        ovf_reg <= 1'b1;
      if (pop && !pop_ok)
        unf_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (mem_reg[gi] == probe_addr);
    end
  endgenerate

`ifdef REGDST_BYPASS_EN
  assign head_dst   = (empty_reg && push_ok) ? sel_dst_c : head_dst_reg;
  assign head_valid = head_valid_reg || (empty_reg && push_ok);
  assign byp_hit    = push && sel_legal && (sel_dst_c == probe_addr);
`else
  assign head_dst   = head_dst_reg;
  assign head_valid = head_valid_reg;
  assign byp_hit    = 1'b0;
`endif

  // Register 0 is hardwired, so it can never be a hazard.
  assign probe_hit = (probe_addr != '0) && ((|match) || byp_hit);

  assign count   = count_reg;
  assign full    = full_reg;
  assign empty   = empty_reg;
  assign sel_err = sel_err_reg;
  assign ovf     = ovf_reg;
  assign unf     = unf_reg;

endmodule

// File: tb/tb_reg_dst_queue.sv
// Directed-vector bench for reg_dst_queue with hand-computed expectations.
module tb_reg_dst_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] regDSTmux;
  logic [4:0] inst20_16, inst15_11, inst25_21, probe_addr;
  logic       push, pop;
  logic [4:0] sel_dst, head_dst;
  logic       head_valid, full, empty, probe_hit, sel_err, ovf, unf;
  logic [2:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  reg_dst_queue dut (
    .clk(clk), .reset(reset), .regDSTmux(regDSTmux),
    .inst20_16(inst20_16), .inst15_11(inst15_11), .inst25_21(inst25_21),
    .push(push), .pop(pop), .probe_addr(probe_addr),
    .sel_dst(sel_dst), .head_dst(head_dst), .head_valid(head_valid),
    .count(count), .full(full), .empty(empty), .probe_hit(probe_hit),
    .sel_err(sel_err), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock edge with the given select/push/pop, then idle inputs.
  task automatic do_cycle(input logic [2:0] code, input logic p, input logic q);
    regDSTmux = code;
    push = p;
    pop = q;
    tick();
    push = 1'b0;
    pop = 1'b0;
    $display("cycle code=%0d push=%0d pop=%0d -> head=%0d cnt=%0d", code, p, q, head_dst, count);
  endtask

  int dec_exp[8]   = '{8, 9, 29, 31, 10, 0, 0, 0};
  int pop_exp[4]   = '{31, 8, 29, 10};
  logic [2:0] wrap_code[6] = '{3'b010, 3'b011, 3'b000, 3'b001, 3'b100, 3'b010};
  int wrap_exp[6]  = '{9, 10, 29, 31, 8, 9};

  initial begin
    reset = 1'b1; regDSTmux = '0; push = 1'b0; pop = 1'b0;
    inst20_16 = 5'd8; inst15_11 = 5'd9; inst25_21 = 5'd10; probe_addr = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_hvalid", head_valid, 0);
    check("rst_hdst", head_dst, 0);
    check("rst_flags", {sel_err, ovf, unf}, 0);

    for (int i = 0; i < 8; i++) begin
      regDSTmux = 3'(i);
      #1;
      $display("decode sel=%0d -> sel_dst=%0d", i, sel_dst);
      check("decode", sel_dst, dec_exp[i]);
    end

    // Fill to full, overflow, full push+pop, drain.
    do_cycle(3'b001, 1, 0);
    check("first_head", head_dst, 9);
    check("first_hvalid", head_valid, 1);
    do_cycle(3'b011, 1, 0);
    do_cycle(3'b000, 1, 0);
    do_cycle(3'b010, 1, 0);
    check("full_count", count, 4);
    check("full_flag", full, 1);
    do_cycle(3'b000, 1, 0);
    check("ovf_count", count, 4);
    check("ovf_flag", ovf, 1);
    do_cycle(3'b100, 1, 1);
    check("fullpp_count", count, 4);
    check("fullpp_head", head_dst, 31);
    for (int i = 0; i < 4; i++) begin
      check("drain_head", head_dst, pop_exp[i]);
      do_cycle(3'b000, 0, 1);
    end
    check("drain_empty", empty, 1);
    check("drain_hvalid", head_valid, 0);
    check("drain_hdst", head_dst, 0);
    check("drain_unf", unf, 0);
    check("ovf_sticky", ovf, 1);

    // Steady push+pop across pointer wrap.
    do_cycle(3'b000, 1, 0);
    do_cycle(3'b001, 1, 0);
    do_cycle(3'b100, 1, 0);
    check("wrap_fill", count, 3);
    for (int i = 0; i < 6; i++) begin
      do_cycle(wrap_code[i], 1, 1);
      check("wrap_head", head_dst, wrap_exp[i]);
      check("wrap_count", count, 3);
    end

    // Illegal selects.
    do_cycle(3'b110, 1, 0);
    check("ill_count", count, 3);
    check("ill_err", sel_err, 1);
    check("ill_head", head_dst, 9);
    tick();
    check("ill_err_clr", sel_err, 0);
    do_cycle(3'b111, 1, 1);
    check("illpop_count", count, 2);
    check("illpop_err", sel_err, 1);
    check("illpop_head", head_dst, 10);
    do_cycle(3'b000, 0, 1);
    check("pop_head", head_dst, 29);
    do_cycle(3'b000, 0, 1);
    check("pop_empty", empty, 1);
    check("pre_unf", unf, 0);
    do_cycle(3'b000, 0, 1);
    check("unf_flag", unf, 1);
    check("unf_count", count, 0);

    // Duplicate destinations and the hazard probe.
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst2_flags", {ovf, unf}, 0);
    do_cycle(3'b001, 1, 0);
    inst20_16 = 5'd0;
    do_cycle(3'b000, 1, 0);
    inst20_16 = 5'd8;
    do_cycle(3'b001, 1, 0);
    check("dup_count", count, 3);
    probe_addr = 5'd0; #1;
    check("probe_zero", probe_hit, 0);
    probe_addr = 5'd8; #1;
    check("probe_absent", probe_hit, 0);
    probe_addr = 5'd9; #1;
    check("probe_hit3", probe_hit, 1);
    do_cycle(3'b000, 0, 1);
    check("probe_hit2", probe_hit, 1);
    do_cycle(3'b000, 0, 1);
    check("probe_hit1", probe_hit, 1);
    probe_addr = 5'd0; #1;
    check("probe_zero_q", probe_hit, 0);
    probe_addr = 5'd9;
    do_cycle(3'b000, 0, 1);
    check("probe_gone", probe_hit, 0);

    // Push+pop on empty: push only, underflow flagged.
    do_cycle(3'b000, 1, 1);
    check("epp_count", count, 1);
    check("epp_head", head_dst, 8);
    check("epp_unf", unf, 1);

    // Mid-stream reset with push asserted.
    do_cycle(3'b001, 1, 0);
    check("mid_count", count, 2);
    reset = 1'b1; regDSTmux = 3'b000; push = 1'b1;
    tick();
    reset = 1'b0; push = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_hvalid", head_valid, 0);
    check("mid_rst_flags", {sel_err, ovf, unf}, 0);

    // Head latency into an empty queue.
    regDSTmux = 3'b011; push = 1'b1; #1;
`ifdef REGDST_BYPASS_EN
    check("byp_head", head_dst, 31);
    check("byp_hvalid", head_valid, 1);
`else
    check("lat_hvalid", head_valid, 0);
    check("lat_head", head_dst, 0);
`endif
    tick();
    push = 1'b0;
    check("lat_head_n1", head_dst, 31);
    check("lat_hvalid_n1", head_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_dst_queue.md
Name: reg_dst_queue

Overview:
- Parametrised successor to the write-destination selector in the multicycle MIPS datapath.
- Selects a destination register number from instruction fields or fixed constants: rt, rd, $sp (29), $ra (31), rs.
- Queues selected numbers for long-latency ops (mult/div, memory) so write-back pops them in order.
- Exposes a hazard probe that flags reads of any pending destination.

Parameters:
- ADDR_W, 5, width of register numbers and instruction fields
- DEPTH, 4, queue entries; power of two, >= 2
- CONST_A, 29, constant destination for sel 3'b010 ($sp)
- CONST_B, 31, constant destination for sel 3'b011 ($ra)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- regDSTmux  input  3  destination select code
- inst20_16  input  ADDR_W  rt field
- inst15_11  input  ADDR_W  rd field
- inst25_21  input  ADDR_W  rs field
- push  input  1  enqueue the currently selected destination
- pop  input  1  dequeue the head (write-back done)
- probe_addr  input  ADDR_W  source register to check for hazard
- sel_dst  output  ADDR_W  combinational selected destination
- head_dst  output  ADDR_W  destination at queue head
- head_valid  output  1  head_dst is meaningful
- count  output  $clog2(DEPTH)+1  entries held
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- probe_hit  output  1  probe_addr matches a valid entry
- sel_err  output  1  registered one-cycle pulse: illegal select on push
- ovf  output  1  sticky: push dropped because queue full
- unf  output  1  sticky: pop while empty

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Decode (combinational) of regDSTmux to sel_dst:
  - 000 -> inst20_16; 001 -> inst15_11; 010 -> CONST_A; 011 -> CONST_B; 100 -> inst25_21.
  - 101..111 are illegal -> sel_dst = 0. No latch is inferred; all codes are covered.
- Reset (on clk edge with reset=1): count=0, read/write pointers=0, head_valid=0, head_dst=0, sel_err=0, ovf=0, unf=0, all entry valid bits cleared.
- Reset dominates push/pop in the same cycle. Contents are discarded mid-operation.
- Push (rising edge):
  - Accepted when regDSTmux is legal and either count < DEPTH or pop is also asserted.
  - Writes sel_dst at the write pointer; the pointer wraps modulo DEPTH.
  - Illegal select with push: no enqueue; sel_err=1 for exactly the next cycle.
  - Push while full without pop: dropped; ovf set and held until reset.
- Pop (rising edge):
  - With count > 0, advances the read pointer (wrapping modulo DEPTH) and clears that entry's valid bit.
  - Pop while empty: ignored; unf set and held until reset.
- Simultaneous push and pop:
  - Non-empty: both occur; count is unchanged, including when full.
  - Empty: only the push takes effect; unf is set.
  - Push with illegal select plus pop: pop occurs; sel_err pulses.
- Head outputs:
  - head_dst/head_valid are registered and reflect the entry at the read pointer after each edge.
  - Latency is push edge N -> head visible during cycle N+1.
  - head_dst = 0 when empty.
- full/empty/count are registered and consistent with the pointers after every edge.
- probe_hit (combinational) = 1 iff probe_addr != 0 and some valid entry equals probe_addr. Register 0 never hazards.
- Duplicate destinations are allowed in the queue. probe_hit stays 1 until the last matching entry is popped.

Optional Feature:
- REGDST_BYPASS_EN, when defined:
  - With the queue empty and push accepted, head_dst = sel_dst and head_valid = 1 combinationally in the same cycle (fall-through).
  - probe_hit also compares against sel_dst when push is asserted with a legal select.
- When undefined: the strict one-cycle latency above applies, and the probe sees stored entries only.

Test Plan:
- Reset, then drive each regDSTmux 000..100 with rt=8, rd=9, rs=10 -> sel_dst = 8, 9, 29, 31, 10 respectively; codes 101/110/111 -> sel_dst=0.
- Push sequence 9, 31, 8, 29 (DEPTH=4) -> full=1 and count=4. A fifth push -> ovf=1, count stays 4. Four pops -> head_dst 9, 31, 8, 29 in order, then empty=1.
- Fill with 3 entries, push+pop together for 6 cycles -> count stays 3 and pointers wrap. Order is preserved across wrap.
- Push regDSTmux=3'b110 -> no enqueue, count unchanged, sel_err high for exactly one cycle. Pop on empty queue -> unf=1.
- Queue holds {9, 0, 9}; probe_addr=9 -> probe_hit=1 until the second 9 is popped. probe_addr=0 -> probe_hit=0 throughout.
- Mid-stream reset with count=2 and push asserted -> next cycle count=0, empty=1, head_valid=0, flags cleared. With REGDST_BYPASS_EN, push 31 into empty queue -> head_dst=31 in the same cycle.
